// File: rtl/rs_syndrome_calc_pkg.sv
// rtl/rs_syndrome_calc_pkg.sv - GF(2^m) constant helpers and FSM state type for the syndrome generator.
package rs_syndrome_calc_pkg;

  localparam int GF_MAXW = 16;
  typedef logic [GF_MAXW-1:0] gf_word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  function automatic gf_word_t gf_mul_x(input gf_word_t a, input int m, input int irrpol);
    gf_word_t r;
    r = a << 1;
    if (r[m]) r = r ^ gf_word_t'(irrpol);
    return r;
  endfunction

  // alpha^k with k reduced modulo the multiplicative group order 2^m-1
  function automatic gf_word_t gf_alpha_pow(input int k, input int m, input int irrpol);
    gf_word_t p;
    int       kk;
    kk = k % ((1 << m) - 1);
    p  = gf_word_t'(1);
    for (int i = 0; i < kk; i++) p = gf_mul_x(p, m, irrpol);
    return p;
  endfunction

  function automatic gf_word_t gf_mult_a_by_b_const(input gf_word_t a, input gf_word_t b,
                                                    input int m, input int irrpol);
    gf_word_t p;
    gf_word_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < m; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_mul_x(aa, m, irrpol);
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_syndrome_calc_if.sv
// rtl/rs_syndrome_calc_if.sv - Symbol input and syndrome output bundle of the syndrome generator.
interface rs_syndrome_calc_if #(
  parameter int m     = 8,
  parameter int check = 32
);
  logic               isop;
  logic               ival;
  logic               ieop;
  logic [m-1:0]       idat;
  logic               oval;
  logic [check*m-1:0] osyndrome;
  logic               ononzero;
  logic               olen_err;
  logic               oabort;

  modport master (
    output isop, ival, ieop, idat,
    input  oval, osyndrome, ononzero, olen_err, oabort
  );

  modport slave (
    input  isop, ival, ieop, idat,
    output oval, osyndrome, ononzero, olen_err, oabort
  );
endinterface

// File: rtl/rs_gf_mult_by_b_const.sv
// rtl/rs_gf_mult_by_b_const.sv - Combinational GF(2^m) multiply by an elaboration-time constant.
module rs_gf_mult_by_b_const
  import rs_syndrome_calc_pkg::*;
#(
  parameter int       m      = 8,
  parameter int       irrpol = 285,
  parameter gf_word_t b      = gf_word_t'(1)
) (
  input  logic [m-1:0] idat,
  output logic [m-1:0] odat
);

  logic [m-1:0] term [m];

  // Column i is b*alpha^i; the product is the XOR of the columns selected by idat
  for (genvar i = 0; i < m; i++) begin : g_col
    localparam gf_word_t COL = gf_mult_a_by_b_const(gf_word_t'(1) << i, b, m, irrpol);
    assign term[i] = idat[i] ? COL[m-1:0] : '0;
  end

  always_comb begin
    odat = '0;
    for (int i = 0; i < m; i++) odat = odat ^ term[i];
  end

endmodule

// File: rtl/rs_syndrome_calc_cell.sv
// rtl/rs_syndrome_calc_cell.sv - One Horner accumulator S <= S*root xor d; osyn is the updated value.
module rs_syndrome_cell
  import rs_syndrome_calc_pkg::*;
#(
  parameter int       m      = 8,
  parameter int       irrpol = 285,
  parameter gf_word_t root   = gf_word_t'(1)
) (
  input  logic         iclk,
  input  logic         ireset_n,
  input  logic         iclkena,
  input  logic         iload,
  input  logic         iacc,
  input  logic [m-1:0] idat,
  output logic [m-1:0] osyn
);

  logic [m-1:0] syn_q;
  logic [m-1:0] syn_d;
  logic [m-1:0] prod;

  rs_gf_mult_by_b_const #(
    .m      (m),
    .irrpol (irrpol),
    .b      (root)
  ) u_mult (
    .idat (syn_q),
    .odat (prod)
  );

  always_comb begin
    syn_d = syn_q;
    if (iload)     syn_d = idat;
    else if (iacc) syn_d = prod ^ idat;
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n)    syn_q <= '0;
    else if (iclkena) syn_q <= syn_d;
  end

  // The top latches the updated value on the eop beat, so expose next state
  assign osyn = syn_d;

endmodule

// File: rtl/rs_syndrome_calc.sv
// rtl/rs_syndrome_calc.sv - Streaming Reed-Solomon syndrome generator with frame FSM and output latch.
module rs_syndrome_calc
  import rs_syndrome_calc_pkg::*;
#(
  parameter int m         = 8,
  parameter int irrpol    = 285,
  parameter int n         = 255,
  parameter int check     = 32,
  parameter int genstart  = 0,
  parameter int rootspace = 1
) (
  input  logic iclk,
  input  logic ireset_n,
  input  logic iclkena,
  rs_syndrome_calc_if.slave bus
);

  localparam int CW = $clog2(n + 2);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               beat, load, acc, fin, abort;
  logic [check*m-1:0] syn_nxt;
  logic [check*m-1:0] syn_q;
  logic               oval_q, oabort_q, nonzero_q, len_err_q;

  always_comb begin
    beat    = bus.ival & iclkena;
    load    = beat & bus.isop;
    acc     = beat & ~bus.isop & (state_q == ACCUM);
    abort   = load & (state_q == ACCUM);
    fin     = beat & bus.ieop & (bus.isop | (state_q == ACCUM));
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = bus.ieop ? IDLE : ACCUM;
      cnt_d   = CW'(1);
    end else if (acc) begin
      if (bus.ieop) state_d = IDLE;
      // Saturate one past n so an overlong frame stays flagged
      if (cnt_q < CW'(n + 1)) cnt_d = cnt_q + 1'b1;
    end
  end

  for (genvar i = 0; i < check; i++) begin : g_cell
    rs_syndrome_cell #(
      .m      (m),
      .irrpol (irrpol),
      .root   (gf_alpha_pow(genstart + i * rootspace, m, irrpol))
    ) u_cell (
      .iclk     (iclk),
      .ireset_n (ireset_n),
      .iclkena  (iclkena),
      .iload    (load),
      .iacc     (acc),
      .idat     (bus.idat),
      .osyn     (syn_nxt[i*m +: m])
    );
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (iclkena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      oval_q    <= 1'b0;
      oabort_q  <= 1'b0;
      syn_q     <= '0;
      nonzero_q <= 1'b0;
      len_err_q <= 1'b0;
    end else if (iclkena) begin
      oval_q   <= fin;
      oabort_q <= abort;
      if (fin) begin
        syn_q     <= syn_nxt;
        nonzero_q <= |syn_nxt;
        len_err_q <= cnt_d > CW'(n);
      end
    end
  end

  assign bus.oval      = oval_q;
  assign bus.oabort    = oabort_q;
  assign bus.osyndrome = syn_q;
  assign bus.ononzero  = nonzero_q;
  assign bus.olen_err  = len_err_q;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// tb/tb_rs_syndrome_calc.sv - Directed self-checking bench for rs_syndrome_calc with m=8, check=4.
module tb_rs_syndrome_calc;

  logic iclk;
  logic ireset_n;
  logic iclkena;
  int   n_chk, n_pass, n_fail;
  int   oval_cnt, abort_cnt, ov0, ab0;

  rs_syndrome_calc_if #(.m(8), .check(4)) bus ();

  rs_syndrome_calc #(
    .m         (8),
    .irrpol    (285),
    .n         (255),
    .check     (4),
    .genstart  (0),
    .rootspace (1)
  ) dut (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .iclkena  (iclkena),
    .bus      (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  always @(negedge iclk) begin
    if (bus.oval === 1'b1)   oval_cnt++;
    if (bus.oabort === 1'b1) abort_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat_(input logic sop, input logic eop, input logic [7:0] d);
    bus.ival = 1'b1;
    bus.isop = sop;
    bus.ieop = eop;
    bus.idat = d;
    @(posedge iclk);
    #1;
    bus.ival = 1'b0;
    bus.isop = 1'b0;
    bus.ieop = 1'b0;
    bus.idat = '0;
  endtask

  task automatic frame(input int len, input logic [7:0] d0, input logic [7:0] dl);
    for (int i = 0; i < len; i++)
      beat_(i == 0, i == len - 1, (i == 0) ? d0 : ((i == len - 1) ? dl : 8'h00));
  endtask

  task automatic idle_cycle();
    @(posedge iclk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; oval_cnt = 0; abort_cnt = 0;
    ireset_n = 1'b0;
    iclkena  = 1'b1;
    bus.ival = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0; bus.idat = '0;
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_oval",    64'(bus.oval),      64'd0);
    chk("rst_oabort",  64'(bus.oabort),    64'd0);
    chk("rst_syn",     64'(bus.osyndrome), 64'd0);
    chk("rst_nonzero", 64'(bus.ononzero),  64'd0);
    chk("rst_len_err", 64'(bus.olen_err),  64'd0);
    ireset_n = 1'b1;
    idle_cycle();

    frame(255, 8'h00, 8'h00);
    chk("zero_oval",    64'(bus.oval),      64'd1);
    chk("zero_syn",     64'(bus.osyndrome), 64'h0);
    chk("zero_nonzero", 64'(bus.ononzero),  64'd0);
    chk("zero_len_err", 64'(bus.olen_err),  64'd0);
    idle_cycle();
    chk("zero_oval_drop", 64'(bus.oval), 64'd0);

    frame(255, 8'h00, 8'h01);
    chk("pos0_syn",     64'(bus.osyndrome), 64'h01010101);
    chk("pos0_nonzero", 64'(bus.ononzero),  64'd1);
    idle_cycle();

    frame(255, 8'h01, 8'h00);
    chk("pos254_syn", 64'(bus.osyndrome), 64'hAD478E01);
    idle_cycle();

    beat_(1'b1, 1'b1, 8'h5A);
    chk("single_oval", 64'(bus.oval),      64'd1);
    chk("single_syn",  64'(bus.osyndrome), 64'h5A5A5A5A);
    beat_(1'b1, 1'b0, 8'h01);
    chk("b2b_oval_drop", 64'(bus.oval), 64'd0);
    beat_(1'b0, 1'b1, 8'h00);
    chk("b2b_oval", 64'(bus.oval),      64'd1);
    chk("b2b_syn",  64'(bus.osyndrome), 64'h08040201);
    idle_cycle();

    beat_(1'b1, 1'b0, 8'h01);
    beat_(1'b0, 1'b0, 8'h02);
    beat_(1'b0, 1'b1, 8'h03);
    chk("s0zero_syn",     64'(bus.osyndrome), 64'h531B0300);
    chk("s0zero_nonzero", 64'(bus.ononzero),  64'd1);
    idle_cycle();

    ov0 = oval_cnt;
    ab0 = abort_cnt;
    for (int i = 0; i < 100; i++) beat_(i == 0, 1'b0, 8'h00);
    beat_(1'b1, 1'b0, 8'h01);
    chk("abort_pulse", 64'(bus.oabort), 64'd1);
    for (int i = 0; i < 253; i++) beat_(1'b0, 1'b0, 8'h00);
    beat_(1'b0, 1'b1, 8'h00);
    chk("abort_syn", 64'(bus.osyndrome), 64'hAD478E01);
    idle_cycle();
    chk("abort_count",      64'(abort_cnt - ab0), 64'd1);
    chk("abort_oval_count", 64'(oval_cnt - ov0),  64'd1);

    frame(257, 8'h01, 8'h00);
    chk("long_len_err", 64'(bus.olen_err),  64'd1);
    chk("long_syn",     64'(bus.osyndrome), 64'h08040201);
    idle_cycle();

    ov0 = oval_cnt;
    for (int i = 0; i < 255; i++) begin
      do begin
        iclkena  = ($urandom_range(0, 3) != 0);
        bus.ival = ($urandom_range(0, 2) != 0);
        if (bus.ival && iclkena) begin
          bus.isop = (i == 0);
          bus.ieop = (i == 254);
          bus.idat = (i == 0) ? 8'h01 : 8'h00;
        end else begin
          bus.isop = 1'($urandom_range(0, 1));
          bus.ieop = 1'($urandom_range(0, 1));
          bus.idat = 8'($urandom_range(0, 255));
        end
        @(posedge iclk);
        #1;
      end while (!(bus.ival && iclkena));
    end
    iclkena  = 1'b1;
    bus.ival = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0; bus.idat = '0;
    chk("stall_oval",    64'(bus.oval),      64'd1);
    chk("stall_syn",     64'(bus.osyndrome), 64'hAD478E01);
    chk("stall_len_err", 64'(bus.olen_err),  64'd0);
    idle_cycle();
    chk("stall_oval_count", 64'(oval_cnt - ov0), 64'd1);

    beat_(1'b1, 1'b0, 8'h07);
    for (int i = 0; i < 49; i++) beat_(1'b0, 1'b0, 8'h00);
    ireset_n = 1'b0;
    #1;
    chk("midrst_syn",     64'(bus.osyndrome), 64'h0);
    chk("midrst_nonzero", 64'(bus.ononzero),  64'd0);
    idle_cycle();
    ireset_n = 1'b1;
    ov0 = oval_cnt;
    for (int i = 0; i < 30; i++) beat_(1'b0, i == 29, 8'h00);
    idle_cycle();
    idle_cycle();
    chk("midrst_no_oval",  64'(oval_cnt - ov0), 64'd0);
    chk("midrst_syn_hold", 64'(bus.osyndrome),  64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
